// File: rtl/cnt_sequencer.sv
// Command sequencer that queues HOLD/RUN/LOAD commands and drives a downstream mod-16 counter,
// tracking the expected counter value alongside it.
module cnt_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_arg,
  input  logic       abort,
  output logic [1:0] mode,
  output logic [3:0] data_in,
  output logic [3:0] exp_cnt,
  output logic       busy,
  output logic       done,
  output logic       wrap
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] OpHold = 2'b00;
  localparam logic [1:0] OpRun  = 2'b01;
  localparam logic [1:0] OpLoad = 2'b10;

  typedef enum logic [0:0] {StIdle, StExec} state_e;

  logic [5:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  state_e        r_state;
  logic [3:0]    r_cnt;
  logic [1:0]    r_mode;
  logic [3:0]    r_data;
  logic [3:0]    r_exp;
  logic          r_done, r_wrap, r_init;

  logic [AW-1:0] w_wr_ptr_d, w_rd_ptr_d;
  logic [CW-1:0] w_count_d;
  state_e        w_state_d;
  logic [3:0]    w_cnt_d, w_data_d, w_exp_d;
  logic [1:0]    w_mode_d;
  logic          w_done_d, w_wrap_d;
  logic          w_full, w_empty, w_push, w_pop, w_last;
  logic [5:0]    w_head;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign cmd_ready = r_init & ~w_full & ~abort;
  assign w_push    = cmd_valid & cmd_ready;
  // r_cnt holds the cycles remaining after the current one
  assign w_last    = (r_state == StExec) && (r_cnt == 4'd0);
  assign w_pop     = ~abort & ~w_empty & ((r_state == StIdle) | w_last);
  assign w_head    = r_mem[r_rd_ptr];

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_mode_d  = r_mode;
    w_data_d  = r_data;
    w_done_d  = 1'b0;
    if (abort) begin
      w_state_d = StIdle;
      w_cnt_d   = 4'd0;
      w_mode_d  = OpHold;
      w_data_d  = 4'd0;
    end else if (w_pop) begin
      w_state_d = StExec;
      w_data_d  = 4'd0;
      unique case (w_head[5:4])
        OpHold: begin w_mode_d = OpHold; w_cnt_d = w_head[3:0]; end
        OpRun:  begin w_mode_d = OpRun;  w_cnt_d = w_head[3:0]; end
        OpLoad: begin w_mode_d = OpLoad; w_cnt_d = 4'd0; w_data_d = w_head[3:0]; end
        default: begin w_mode_d = OpHold; w_cnt_d = 4'd0; end
      endcase
      w_done_d = (w_cnt_d == 4'd0);
    end else if ((r_state == StExec) && !w_last) begin
      w_cnt_d  = r_cnt - 4'd1;
      w_done_d = (r_cnt == 4'd1);
    end else begin
      w_state_d = StIdle;
      w_cnt_d   = 4'd0;
      w_mode_d  = OpHold;
      w_data_d  = 4'd0;
    end
  end

  always_comb begin
    w_exp_d = r_exp;
    if (r_mode == OpRun)       w_exp_d = r_exp + 4'd1;
    else if (r_mode == OpLoad) w_exp_d = r_data;
    w_wrap_d = (r_mode == OpRun) && (r_exp == 4'hF);
  end

  always_comb begin
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    w_count_d  = r_count;
    if (abort) begin
      w_wr_ptr_d = '0;
      w_rd_ptr_d = '0;
      w_count_d  = '0;
    end else begin
      if (w_push) w_wr_ptr_d = r_wr_ptr + 1'b1;
      if (w_pop)  w_rd_ptr_d = r_rd_ptr + 1'b1;
      w_count_d = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_op, cmd_arg};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= StIdle;
      r_cnt    <= 4'd0;
      r_mode   <= OpHold;
      r_data   <= 4'd0;
      r_exp    <= 4'd0;
      r_done   <= 1'b0;
      r_wrap   <= 1'b0;
      r_init   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_mode   <= w_mode_d;
      r_data   <= w_data_d;
      r_exp    <= w_exp_d;
      r_done   <= w_done_d;
      r_wrap   <= w_wrap_d;
      r_init   <= 1'b1;
    end
  end

  assign mode    = r_mode;
  assign data_in = r_data;
  assign exp_cnt = r_exp;
  assign done    = r_done;
  assign wrap    = r_wrap;
  assign busy    = (r_state == StExec) | ~w_empty;

endmodule

// File: tb/tb_cnt_sequencer.sv
// Directed bench for cnt_sequencer: a vector table for single-command behaviour plus
// hand-written sequences for FIFO back-pressure, abort and mid-command reset.
module tb_cnt_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic       abort;
  logic [1:0] mode;
  logic [3:0] data_in;
  logic [3:0] exp_cnt;
  logic       busy;
  logic       done;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  cnt_sequencer #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_arg  (cmd_arg),
    .abort    (abort),
    .mode     (mode),
    .data_in  (data_in),
    .exp_cnt  (exp_cnt),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v;
    logic [1:0] op;
    logic [3:0] arg;
    logic [1:0] mode;
    logic [3:0] data;
    logic [3:0] exp;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       rdy;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic r, input logic v, input logic [1:0] op,
                              input logic [3:0] arg, input logic [1:0] m, input logic [3:0] d,
                              input logic [3:0] e, input logic b, input logic dn,
                              input logic w, input logic rd);
    vec_t t;
    t.rst = r; t.v = v; t.op = op; t.arg = arg; t.mode = m; t.data = d; t.exp = e;
    t.busy = b; t.done = dn; t.wrap = w; t.rdy = rd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are cleared after each edge so cmd_ready reflects state alone when checked.
  task automatic tick();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 4'd0; abort = 1'b0;

    // reset (command offered during reset is ignored)
    vecs[0]  = mk(0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 2, 7,  0, 0,  0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0,  0, 0,  0, 0, 0, 0, 1);
    // LOAD 9
    vecs[3]  = mk(1, 1, 2, 9,  0, 0,  0, 1, 0, 0, 1);
    vecs[4]  = mk(1, 0, 0, 0,  2, 9,  0, 1, 1, 0, 1);
    vecs[5]  = mk(1, 0, 0, 0,  0, 0,  9, 0, 0, 0, 1);
    // LOAD 14 then RUN 3 back-to-back, wrapping through 15 -> 0
    vecs[6]  = mk(1, 1, 2, 14, 0, 0,  9, 1, 0, 0, 1);
    vecs[7]  = mk(1, 1, 1, 3,  2, 14, 9, 1, 1, 0, 1);
    vecs[8]  = mk(1, 0, 0, 0,  1, 0, 14, 1, 0, 0, 1);
    vecs[9]  = mk(1, 0, 0, 0,  1, 0, 15, 1, 0, 0, 1);
    vecs[10] = mk(1, 0, 0, 0,  1, 0,  0, 1, 0, 1, 1);
    vecs[11] = mk(1, 0, 0, 0,  1, 0,  1, 1, 1, 0, 1);
    vecs[12] = mk(1, 0, 0, 0,  0, 0,  2, 0, 0, 0, 1);
    // reserved opcode behaves as a 1-cycle HOLD
    vecs[13] = mk(1, 1, 3, 5,  0, 0,  2, 1, 0, 0, 1);
    vecs[14] = mk(1, 0, 0, 0,  0, 0,  2, 1, 1, 0, 1);
    vecs[15] = mk(1, 0, 0, 0,  0, 0,  2, 0, 0, 0, 1);
    // HOLD 1: two cycles
    vecs[16] = mk(1, 1, 0, 1,  0, 0,  2, 1, 0, 0, 1);
    vecs[17] = mk(1, 0, 0, 0,  0, 0,  2, 1, 0, 0, 1);
    vecs[18] = mk(1, 0, 0, 0,  0, 0,  2, 1, 1, 0, 1);
    vecs[19] = mk(1, 0, 0, 0,  0, 0,  2, 0, 0, 0, 1);
    // RUN 0: single count cycle
    vecs[20] = mk(1, 1, 1, 0,  0, 0,  2, 1, 0, 0, 1);
    vecs[21] = mk(1, 0, 0, 0,  1, 0,  2, 1, 1, 0, 1);
    vecs[22] = mk(1, 0, 0, 0,  0, 0,  3, 0, 0, 0, 1);

    for (int i = 0; i < 23; i++) begin
      rst       = vecs[i].rst;
      cmd_valid = vecs[i].v;
      cmd_op    = vecs[i].op;
      cmd_arg   = vecs[i].arg;
      tick();
      chk($sformatf("v%0d mode", i),    32'(mode),      32'(vecs[i].mode));
      chk($sformatf("v%0d data_in", i), 32'(data_in),   32'(vecs[i].data));
      chk($sformatf("v%0d exp_cnt", i), 32'(exp_cnt),   32'(vecs[i].exp));
      chk($sformatf("v%0d busy", i),    32'(busy),      32'(vecs[i].busy));
      chk($sformatf("v%0d done", i),    32'(done),      32'(vecs[i].done));
      chk($sformatf("v%0d wrap", i),    32'(wrap),      32'(vecs[i].wrap));
      chk($sformatf("v%0d ready", i),   32'(cmd_ready), 32'(vecs[i].rdy));
    end

    // FIFO back-pressure: HOLD 15 occupies execution while 4 LOADs fill the queue
    drive(2'd0, 4'd15);
    tick();
    for (int j = 1; j <= 4; j++) begin
      drive(2'd2, 4'(j));
      tick();
    end
    chk("full ready", 32'(cmd_ready), 32'd0);
    for (int j = 0; j < 12; j++) begin
      chk($sformatf("full stall%0d ready", j), 32'(cmd_ready), 32'd0);
      drive(2'd2, 4'd5);
      tick();
    end
    chk("hold15 done", 32'(done), 32'd1);
    chk("hold15 last ready", 32'(cmd_ready), 32'd0);
    drive(2'd2, 4'd5);
    tick();
    chk("first pop ready", 32'(cmd_ready), 32'd1);
    chk("first pop mode", 32'(mode), 32'd2);
    chk("first pop data", 32'(data_in), 32'd1);
    drive(2'd2, 4'd5);
    tick();
    chk("q data2", 32'(data_in), 32'd2);
    for (int j = 3; j <= 5; j++) begin
      tick();
      chk($sformatf("q data%0d", j), 32'(data_in), 32'(j));
    end
    tick();
    chk("drain exp", 32'(exp_cnt), 32'd5);
    chk("drain busy", 32'(busy), 32'd0);
    chk("drain mode", 32'(mode), 32'd0);

    // Abort on the 3rd cycle of RUN 7 with two LOADs queued
    drive(2'd1, 4'd7);
    tick();
    drive(2'd2, 4'd9);
    tick();
    chk("run c1 mode", 32'(mode), 32'd1);
    chk("run c1 exp", 32'(exp_cnt), 32'd5);
    drive(2'd2, 4'd12);
    tick();
    chk("run c2 exp", 32'(exp_cnt), 32'd6);
    tick();
    chk("run c3 mode", 32'(mode), 32'd1);
    chk("run c3 exp", 32'(exp_cnt), 32'd7);
    abort = 1'b1;
    drive(2'd2, 4'd1);
    #1;
    chk("abort ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("abort mode", 32'(mode), 32'd0);
    chk("abort data", 32'(data_in), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort exp", 32'(exp_cnt), 32'd8);
    chk("abort ready after", 32'(cmd_ready), 32'd1);
    for (int j = 0; j < 6; j++) begin
      tick();
      chk($sformatf("post abort%0d mode", j), 32'(mode), 32'd0);
      chk($sformatf("post abort%0d busy", j), 32'(busy), 32'd0);
      chk($sformatf("post abort%0d done", j), 32'(done), 32'd0);
      chk($sformatf("post abort%0d exp", j), 32'(exp_cnt), 32'd8);
    end

    // Reset in the middle of HOLD 5, then a LOAD 3 after release
    drive(2'd0, 4'd5);
    tick();
    tick();
    chk("hold5 busy", 32'(busy), 32'd1);
    tick();
    chk("hold5 done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst mode", 32'(mode), 32'd0);
    chk("rst data", 32'(data_in), 32'd0);
    chk("rst exp", 32'(exp_cnt), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst wrap", 32'(wrap), 32'd0);
    chk("rst ready", 32'(cmd_ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("release ready", 32'(cmd_ready), 32'd1);
    chk("release busy", 32'(busy), 32'd0);
    chk("release done", 32'(done), 32'd0);
    drive(2'd2, 4'd3);
    tick();
    tick();
    chk("load3 mode", 32'(mode), 32'd2);
    chk("load3 data", 32'(data_in), 32'd3);
    chk("load3 done", 32'(done), 32'd1);
    tick();
    chk("load3 exp", 32'(exp_cnt), 32'd3);
    chk("load3 busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
